// File: rtl/apb_pkg.sv
// Shared constants for the round-robin APB master: FSM encodings and default bus widths.
package apb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SETUP  = 2'd1;
  localparam state_t ACCESS = 2'd2;

  localparam int AW_DEFAULT = 4;
  localparam int DW_DEFAULT = 8;

endpackage

// File: rtl/apb_rr_master_if.sv
// APB bus bundle between the round-robin master and a single slave.
interface apb_rr_master_if #(
  parameter int AW = apb_pkg::AW_DEFAULT,
  parameter int DW = apb_pkg::DW_DEFAULT
);

  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready
  );

endinterface

// File: rtl/apb_rr_master_rr_arbiter.sv
// Combinational round-robin pick: first pending request at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  int pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    pos       = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master: shares one APB slave among NREQ requesters, with wait-state timeout.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = AW_DEFAULT,
  parameter int DW      = DW_DEFAULT,
  parameter int TIMEOUT = 16
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      rsp_done,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 rsp_err,
  apb_rr_master_if.master      bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [NREQ-1:0] grant_oh;
  logic [CW-1:0]   wait_cnt;

  logic [NREQ-1:0] arb_oh;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            start_grant;
  logic            timeout_hit;
  logic [IW-1:0]   next_ptr;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_oh),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // No grant during the completion cycle, so the finished requester has a cycle to drop req_valid.
  assign start_grant = (state == IDLE) && arb_any && (rsp_done == '0);
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == TO_LAST);
  assign next_ptr    = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_oh    <= '0;
      wait_cnt    <= '0;
      rsp_done    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      bus.psel    <= 1'b0;
      bus.penable <= 1'b0;
      bus.pwrite  <= 1'b0;
      bus.paddr   <= '0;
      bus.pwdata  <= '0;
    end else begin
      rsp_done  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_grant) begin
            grant_oh   <= arb_oh;
            rr_ptr     <= next_ptr;
            wait_cnt   <= '0;
            bus.paddr  <= req_addr[int'(arb_idx)*AW +: AW];
            bus.pwdata <= req_wdata[int'(arb_idx)*DW +: DW];
            bus.pwrite <= req_write[arb_idx];
            bus.psel   <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          bus.penable <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            bus.psel    <= 1'b0;
            bus.penable <= 1'b0;
            rsp_done    <= grant_oh;
            rsp_rdata   <= bus.pwrite ? '0 : bus.prdata;
            state       <= IDLE;
          end else if (timeout_hit) begin
            bus.psel    <= 1'b0;
            bus.penable <= 1'b0;
            rsp_done    <= grant_oh;
            rsp_err     <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          bus.psel    <= 1'b0;
          bus.penable <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master with a small memory-backed APB slave.
module tb_apb_rr_master;

  localparam int NREQ    = 4;
  localparam int AW      = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic                 preset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      rsp_done;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic                 pready_drv;
  logic [7:0]           mem [16];

  int checks   = 0;
  int failures = 0;

  apb_rr_master_if #(.AW(AW), .DW(DW)) bus ();

  apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_done  (rsp_done),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus       (bus)
  );

  assign bus.pready = pready_drv;
  assign bus.prdata = mem[bus.paddr];

  // Slave memory preloads 8'h10+addr whenever reset is held, otherwise commits completed writes.
  always @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(8'h10 + i);
    end else if (bus.psel && bus.penable && bus.pready && bus.pwrite) begin
      mem[bus.paddr] <= bus.pwdata;
    end
  end

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setReq(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  int served;
  int exp_idx [5] = '{0, 1, 2, 3, 0};

  initial begin
    preset     = 1'b1;
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    pready_drv = 1'b1;
    applyStimulus(2);

    checkOutput("reset_ctrl", {29'd0, bus.psel, bus.penable, bus.pwrite}, 32'd0);
    checkOutput("reset_paddr", {28'd0, bus.paddr}, 32'd0);
    checkOutput("reset_pwdata", {24'd0, bus.pwdata}, 32'd0);
    checkOutput("reset_rsp", {27'd0, rsp_done, rsp_err}, 32'd0);
    checkOutput("reset_rdata", {24'd0, rsp_rdata}, 32'd0);

    // Single write from requester 0, no wait states
    preset = 1'b0;
    setReq(0, 1'b1, 4'h3, 8'hA5);
    applyStimulus(1);
    checkOutput("wr_setup_ctrl", {30'd0, bus.psel, bus.penable}, 32'h2);
    checkOutput("wr_setup_paddr", {28'd0, bus.paddr}, 32'h3);
    checkOutput("wr_setup_pwrite", {31'd0, bus.pwrite}, 32'h1);
    checkOutput("wr_setup_pwdata", {24'd0, bus.pwdata}, 32'hA5);
    applyStimulus(1);
    checkOutput("wr_access_ctrl", {30'd0, bus.psel, bus.penable}, 32'h3);
    checkOutput("wr_access_done", {28'd0, rsp_done}, 32'h0);
    applyStimulus(1);
    checkOutput("wr_done", {28'd0, rsp_done}, 32'h1);
    checkOutput("wr_err", {31'd0, rsp_err}, 32'h0);
    checkOutput("wr_rdata", {24'd0, rsp_rdata}, 32'h0);
    checkOutput("wr_done_ctrl", {30'd0, bus.psel, bus.penable}, 32'h0);
    req_valid[0] = 1'b0;
    applyStimulus(1);
    checkOutput("wr_mem3", {24'd0, mem[3]}, 32'hA5);
    checkOutput("wr_no_reissue", {31'd0, bus.psel}, 32'h0);

    // Read from requester 2 with two wait states
    setReq(2, 1'b0, 4'h3, 8'h00);
    pready_drv = 1'b0;
    applyStimulus(1);
    checkOutput("rd_setup_ctrl", {30'd0, bus.psel, bus.penable}, 32'h2);
    checkOutput("rd_setup_pwrite", {31'd0, bus.pwrite}, 32'h0);
    applyStimulus(2);
    checkOutput("rd_wait_ctrl", {30'd0, bus.psel, bus.penable}, 32'h3);
    checkOutput("rd_wait_done", {28'd0, rsp_done}, 32'h0);
    applyStimulus(1);
    pready_drv = 1'b1;
    checkOutput("rd_wait2_done", {28'd0, rsp_done}, 32'h0);
    applyStimulus(1);
    checkOutput("rd_done", {28'd0, rsp_done}, 32'h4);
    checkOutput("rd_rdata", {24'd0, rsp_rdata}, 32'hA5);
    checkOutput("rd_err", {31'd0, rsp_err}, 32'h0);
    req_valid[2] = 1'b0;
    applyStimulus(1);

    // Contention: all four read from reset, requester 0 re-requests after requester 1 finishes
    preset = 1'b1;
    applyStimulus(1);
    preset = 1'b0;
    for (int i = 0; i < NREQ; i++) setReq(i, 1'b0, 4'(8 + i), 8'h00);
    served = 0;
    for (int cyc = 0; cyc < 60 && served < 5; cyc++) begin
      applyStimulus(1);
      if (rsp_done != '0) begin
        checkOutput("rr_order", {28'd0, rsp_done}, 32'(1 << exp_idx[served]));
        checkOutput("rr_rdata", {24'd0, rsp_rdata}, 32'(8'h18 + exp_idx[served]));
        checkOutput("rr_psel_drop", {31'd0, bus.psel}, 32'h0);
        req_valid = req_valid & ~rsp_done;
        if (served == 1) req_valid[0] = 1'b1;
        served++;
      end
    end
    checkOutput("rr_served", 32'(served), 32'd5);
    req_valid = '0;
    applyStimulus(1);

    // Timeout: slave never ready
    setReq(3, 1'b0, 4'h5, 8'h00);
    pready_drv = 1'b0;
    applyStimulus(17);
    checkOutput("to_last_wait_ctrl", {30'd0, bus.psel, bus.penable}, 32'h3);
    checkOutput("to_last_wait_done", {28'd0, rsp_done}, 32'h0);
    applyStimulus(1);
    checkOutput("to_done", {28'd0, rsp_done}, 32'h8);
    checkOutput("to_err", {31'd0, rsp_err}, 32'h1);
    checkOutput("to_rdata", {24'd0, rsp_rdata}, 32'h0);
    checkOutput("to_ctrl", {30'd0, bus.psel, bus.penable}, 32'h0);
    req_valid[3] = 1'b0;
    applyStimulus(1);

    // Reset during a wait state, then requester 0 wins first
    setReq(1, 1'b0, 4'h2, 8'h00);
    applyStimulus(3);
    checkOutput("rst_wait_ctrl", {30'd0, bus.psel, bus.penable}, 32'h3);
    preset = 1'b1;
    applyStimulus(1);
    checkOutput("rst_abort_ctrl", {30'd0, bus.psel, bus.penable}, 32'h0);
    checkOutput("rst_abort_done", {28'd0, rsp_done}, 32'h0);
    preset = 1'b0;
    setReq(0, 1'b0, 4'h6, 8'h00);
    pready_drv = 1'b1;
    applyStimulus(1);
    checkOutput("rst_next_paddr", {28'd0, bus.paddr}, 32'h6);
    applyStimulus(2);
    checkOutput("rst_next_done", {28'd0, rsp_done}, 32'h1);
    checkOutput("rst_next_rdata", {24'd0, rsp_rdata}, 32'h16);
    req_valid[0] = 1'b0;
    pready_drv   = 1'b0;

    // Requester 1 changes its address after the grant
    applyStimulus(2);
    checkOutput("fc_setup_paddr", {28'd0, bus.paddr}, 32'h2);
    req_addr[1*AW +: AW] = 4'hF;
    applyStimulus(1);
    checkOutput("fc_access_paddr", {28'd0, bus.paddr}, 32'h2);
    applyStimulus(1);
    checkOutput("fc_wait_paddr", {28'd0, bus.paddr}, 32'h2);
    checkOutput("fc_wait_ctrl", {30'd0, bus.psel, bus.penable}, 32'h3);
    pready_drv = 1'b1;
    applyStimulus(1);
    checkOutput("fc_done", {28'd0, rsp_done}, 32'h2);
    checkOutput("fc_rdata", {24'd0, rsp_rdata}, 32'h12);
    req_valid[1] = 1'b0;
    applyStimulus(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin APB master that shares one APB slave port (4-bit address, 8-bit data, wait-state capable) among NREQ local requesters.
- Each cycle it arbitrates among pending requests, then runs a standard APB SETUP/ACCESS transfer.
- Inserts as many wait states as the slave demands via pready.
- Returns read data and a completion pulse to the winning requester.
- A wait-state timeout stops a stuck slave from hanging the bus.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 4, APB address width
- DW, 8, APB data width
- TIMEOUT, 16, maximum consecutive ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
- pclk  in  1  clock
- preset  in  1  synchronous active-high reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_write  in  NREQ  1 = write, 0 = read, per requester
- req_addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW]
- rsp_done  out  NREQ  one-cycle completion pulse, one-hot
- rsp_rdata  out  DW  read data, valid while rsp_done is nonzero
- rsp_err  out  1  timeout abort flag, valid while rsp_done is nonzero
- paddr  out  AW  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DW  APB write data
- prdata  in  DW  APB read data
- pready  in  1  APB ready; low = wait state

Behaviour:
- All outputs registered.
- Reset (preset=1 at a clock edge) forces:
  - state to IDLE
  - psel, penable, pwrite to 0; paddr, pwdata to 0
  - rsp_done, rsp_rdata, rsp_err to 0
  - round-robin pointer and timeout counter to 0
- States:
  - IDLE: if any req_valid, grant the winner, latch its write/addr/wdata, move to SETUP. Otherwise stay.
  - SETUP: psel=1, penable=0, address, direction and data driven from the latched values. Unconditionally go to ACCESS.
  - ACCESS: psel=1, penable=1, paddr/pwrite/pwdata held stable.
    - pready=1: go to IDLE, pulse rsp_done[grant] in the next cycle. On a read, rsp_rdata = prdata sampled at that edge; on a write, rsp_rdata = 0. rsp_err=0.
    - pready=0: stay in ACCESS and increment the wait counter.
    - If TIMEOUT>0 and the counter reaches TIMEOUT: go to IDLE, rsp_done[grant]=1, rsp_err=1, rsp_rdata=0.
- psel and penable drop to 0 in the cycle rsp_done pulses.
- Arbitration:
  - Round-robin, evaluated only in IDLE.
  - Search starts at (last_grant+1) mod NREQ; after reset, requester 0 has top priority.
  - The pointer updates only on a grant.
- Latency with no wait states:
  - req_valid seen in IDLE at cycle 0; SETUP in cycle 1; ACCESS in cycle 2; rsp_done in cycle 3.
  - Each wait state adds one cycle.
  - Minimum spacing between back-to-back transfers is 4 cycles; the controller is back in IDLE during the rsp_done cycle.
- Requester contract:
  - Hold req_valid and its fields until its own rsp_done.
  - Drop req_valid in the cycle after rsp_done, or the request is re-issued.
  - Changes to a requester's fields after the grant do not affect the bus transfer.
- rsp_done is never asserted for a requester with req_valid=0 at grant time.
- At most one bit of rsp_done is high in any cycle.
- Reset in SETUP or ACCESS: bus returns to idle on the next edge; no rsp_done for the aborted transfer.
- The wait counter is sized for TIMEOUT and clears on entry to SETUP.

Decomposition:
- Package apb_pkg holds:
  - state localparams IDLE=0, SETUP=1, ACCESS=2
  - the default AW/DW widths
- Sub-module rr_arbiter (combinational request/pointer to one-hot grant plus index) is natural. The pointer register stays in apb_rr_master.

Test Plan:
- Single write: requester 0 write, addr 4'h3, wdata 8'hA5, pready tied 1 -> psel at cycle 1, penable at cycle 2, rsp_done=4'b0001 at cycle 3, rsp_err=0; slave mem[3]=8'hA5.
- Read with 2 wait states: requester 2 reads addr 4'h3, pready low for 2 ACCESS cycles -> ACCESS lasts 3 cycles, rsp_done=4'b0100 at cycle 5, rsp_rdata=8'hA5.
- Contention: all four req_valid high from reset -> grant order 0,1,2,3. Requester 0 re-requests after completion -> it is served after 3.
- Timeout: TIMEOUT=16, pready held 0 -> after 16 ACCESS cycles rsp_done pulses with rsp_err=1, rsp_rdata=8'h00, and psel drops the same cycle.
- Reset in ACCESS: preset=1 during a wait state -> next cycle psel=penable=0, rsp_done=0. The next request goes to requester 0 first.
- Field change after grant: requester 1 changes req_addr during ACCESS -> paddr stays at the latched value throughout the transfer.
